mlp_sequencer: RTL and testbench
================================

// Module: mlp_sequencer
// PURPOSE
//  Time-multiplexes one shared neuron adder (sum = a + b + bias, mod 2^DW) to evaluate a
//  2-input, N_HID-hidden, 1-output MLP: one hidden neuron per cycle, then the output neuron.
//  Holds the weight/bias register file and applies ReLU to every neuron result.
//  Input and output use a start/busy and valid/ready handshake. Sits between the host
//  and the neuron datapath.
// PARAMETERS
//  DW     4  neuron datapath width; two's complement; weights and biases are DW bits
//  IW     2  width of inputs x0/x1 and of out (unsigned)
//  N_HID  2  hidden neurons; fixed at 2 in this revision, so the cfg map below holds
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      synchronous reset, active-low
//  cfg_we     in   1      weight write strobe
//  cfg_addr   in   4      0:w00 1:w01 2:w10 3:w11 4:u0 5:u1 6:b0 7:b1 8:bo
//  cfg_data   in   DW     weight/bias value
//  start      in   1      request an evaluation; sampled only in IDLE
//  x0, x1     in   IW     network inputs, zero-extended to DW; latched on start accept
//  busy       out  1      1 in any state other than IDLE
//  nrn_a      out  DW     neuron operand a
//  nrn_b      out  DW     neuron operand b
//  nrn_bias   out  DW     neuron bias
//  nrn_sum    in   DW     neuron result; combinational from nrn_a/b/bias, same cycle
//  out_valid  out  1      out holds a result
//  out        out  IW     relu(output sum)[IW-1:0]
//  out_ready  in   1      consumer accepts out
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): state=IDLE; busy=0; out_valid=0; out=0; all weights,
//    biases, latched x and hidden regs=0. Reset mid-evaluation aborts the evaluation.
//    No result is produced.
//  - FSM IDLE -> HID0 -> HID1 -> OUTN -> HOLD -> IDLE.
//    IDLE: start=1 at edge T latches x0/x1 and moves to HID0.
//    HID0: a=x0*w00, b=x1*w01, bias=b0. At edge T+1, h0=relu(nrn_sum); go to HID1.
//    HID1: a=x0*w10, b=x1*w11, bias=b1. At edge T+2, h1=relu(nrn_sum); go to OUTN.
//    OUTN: a=h0*u0, b=h1*u1, bias=bo. At edge T+3, out=relu(nrn_sum)[IW-1:0] and
//      out_valid=1; go to HOLD.
//    HOLD: out and out_valid stay stable until out_ready=1 at an edge. That edge clears
//      out_valid, keeps out's value and moves to IDLE.
//  - Latency: start edge to out_valid high is 3 cycles. Minimum start-to-start spacing is
//    5 cycles when out_ready is tied high.
//  - Products: full signed DW x DW multiply, truncated to the low DW bits (mod 2^DW).
//    Zero-extended inputs are treated as non-negative.
//  - relu(s) = 0 if s[DW-1]=1, else s.
//  - In IDLE and HOLD, nrn_a, nrn_b and nrn_bias are driven to 0.
//  - start is ignored while busy. There is no queuing.
//  - start and out_ready both high in HOLD: only the output handshake completes. start
//    must be re-asserted in IDLE.
//  - cfg writes take effect only in IDLE. Writes while busy are dropped. Writes with
//    cfg_addr>8 are dropped. A write and an accepted start in the same IDLE cycle: the
//    write lands, and the evaluation uses the new value (the first use is at HID0 or later).
//  - x0/x1 changes after start is accepted do not affect the evaluation in progress.
// TESTING
//  1 Load w00=1 w01=1 b0=0 w10=1 w11=F b1=0 u0=1 u1=1 bo=F; start with x0=2 x1=1
//    -> h0=3, h1=1 (17 mod 16), out=3.
//  2 Same weights, bo=A -> output sum=E (negative) -> out=0 (ReLU clamp).
//  3 Timing: start at edge T -> busy=1 after T; out_valid=1 after T+3; hold out_ready=0
//    for 4 cycles -> out stays stable; out_ready=1 -> out_valid=0 and busy=0 next cycle.
//  4 While busy: write cfg_addr=0 data=7 and pulse start -> both ignored. A rerun in
//    IDLE gives the same out as before. Write addr=9 in IDLE -> no register changes.
//  5 Assert rst_n=0 during HID1 -> next cycle busy=0, out_valid=0, weights=0. Start with
//    all-zero weights -> out=0.
//  6 In HOLD, drive start=1 and out_ready=1 together -> returns to IDLE with no new run.
//    start in the following cycle -> run begins.

Source files
------------

// File: rtl/mlp_sequencer_if.sv
// -----------------------------------------------------------------------------
// mlp_sequencer_if
//
// Purpose:
//   Bundles every non-clock signal of mlp_sequencer:
//     - the host side (configuration writes, start/busy request, valid/ready result)
//     - the shared neuron adder side (operands out, sum back in)
//   The sequencer connects through the slave modport. The host, which in a
//   testbench also models the neuron adder, connects through the master modport.
//
// Signals:
//   cfg_we, cfg_addr, cfg_data   weight/bias register write port
//   start, x0, x1                evaluation request and network inputs
//   busy                         sequencer is not idle
//   nrn_a, nrn_b, nrn_bias       operands presented to the neuron adder
//   nrn_sum                      combinational result from the neuron adder
//   out_valid, out, out_ready    result handshake
//
// Handshakes:
//   start/busy : a request is taken only when busy=0 and start=1 at a rising
//                edge. While busy=1, start is ignored and nothing is queued.
//   valid/ready: out_valid rises together with out. Both stay stable until
//                out_valid=1 and out_ready=1 meet at a rising edge. That edge
//                completes the transfer and drops out_valid. out keeps its value.
// -----------------------------------------------------------------------------
interface mlp_sequencer_if #(
    parameter int DW = 4,
    parameter int IW = 2
);
    logic          cfg_we;
    logic [3:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic          start;
    logic [IW-1:0] x0;
    logic [IW-1:0] x1;
    logic          busy;
    logic [DW-1:0] nrn_a;
    logic [DW-1:0] nrn_b;
    logic [DW-1:0] nrn_bias;
    logic [DW-1:0] nrn_sum;
    logic          out_valid;
    logic [IW-1:0] out;
    logic          out_ready;

    modport slave (
        input  cfg_we, cfg_addr, cfg_data, start, x0, x1, nrn_sum, out_ready,
        output busy, nrn_a, nrn_b, nrn_bias, out_valid, out
    );

    modport master (
        output cfg_we, cfg_addr, cfg_data, start, x0, x1, nrn_sum, out_ready,
        input  busy, nrn_a, nrn_b, nrn_bias, out_valid, out
    );
endinterface

// File: rtl/mlp_sequencer.sv
// -----------------------------------------------------------------------------
// mlp_sequencer
//
// Purpose:
//   Evaluates a 2-input, 2-hidden, 1-output MLP on one shared neuron adder
//   (sum = a + b + bias, mod 2^DW). The adder is used once per cycle:
//     HID0  produces hidden neuron 0
//     HID1  produces hidden neuron 1
//     OUTN  produces the output neuron
//   Every neuron result goes through ReLU. This block also holds the
//   weight/bias register file.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous active-low reset. It aborts any evaluation in progress.
//   bus      mlp_sequencer_if.slave: configuration, start/busy, neuron operands
//            and sum, and the out valid/ready handshake
//   state_o  current FSM state, for debug and checker binding
//
// Configuration map (cfg_addr):
//   0:w00  1:w01  2:w10  3:w11  4:u0  5:u1  6:b0  7:b1  8:bo
//   A write lands only in IDLE. Addresses above 8 are dropped.
// -----------------------------------------------------------------------------
module mlp_sequencer #(
    parameter int DW    = 4,
    parameter int IW    = 2,
    parameter int N_HID = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mlp_sequencer_if.slave bus,
    output logic [2:0]     state_o
);

    // Register file:
    //   2*N_HID input weights + N_HID output weights + N_HID hidden biases
    //   + 1 output bias
    localparam int NUM_REGS = 4 * N_HID + 1;

    localparam int A_W00 = 0;
    localparam int A_W01 = 1;
    localparam int A_W10 = 2;
    localparam int A_W11 = 3;
    localparam int A_U0  = 4;
    localparam int A_U1  = 5;
    localparam int A_B0  = 6;
    localparam int A_B1  = 7;
    localparam int A_BO  = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HID0 = 3'd1,
        S_HID1 = 3'd2,
        S_OUTN = 3'd3,
        S_HOLD = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] w_q [NUM_REGS];
    logic [IW-1:0] x0_q, x1_q;
    logic [DW-1:0] h0_q, h1_q;
    logic [IW-1:0] out_q;
    logic          out_valid_q;

    // Operand selection for the two products and the bias
    logic [DW-1:0] mul_a_l, mul_a_r;
    logic [DW-1:0] mul_b_l, mul_b_r;
    logic [DW-1:0] bias_sel;
    logic [DW-1:0] prod_a, prod_b;
    logic [DW-1:0] relu_sum;
    logic [DW-1:0] x0_ext, x1_ext;

    // Inputs are unsigned, so zero-extension keeps them non-negative in the
    // two's complement product.
    assign x0_ext = {{(DW-IW){1'b0}}, x0_q};
    assign x1_ext = {{(DW-IW){1'b0}}, x1_q};

    // The low DW bits of a product are the same for signed and unsigned
    // operands. A DW-wide unsigned multiply therefore gives the truncated
    // signed product directly.
    assign prod_a = mul_a_l * mul_a_r;
    assign prod_b = mul_b_l * mul_b_r;

    assign relu_sum = bus.nrn_sum[DW-1] ? '0 : bus.nrn_sum;

    // ---------------------------------------------------------------------
    // Next-state and operand selection
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mul_a_l  = '0;
        mul_a_r  = '0;
        mul_b_l  = '0;
        mul_b_r  = '0;
        bias_sel = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_HID0;
                end
            end
            S_HID0: begin
                mul_a_l  = x0_ext;
                mul_a_r  = w_q[A_W00];
                mul_b_l  = x1_ext;
                mul_b_r  = w_q[A_W01];
                bias_sel = w_q[A_B0];
                state_d  = S_HID1;
            end
            S_HID1: begin
                mul_a_l  = x0_ext;
                mul_a_r  = w_q[A_W10];
                mul_b_l  = x1_ext;
                mul_b_r  = w_q[A_W11];
                bias_sel = w_q[A_B1];
                state_d  = S_OUTN;
            end
            S_OUTN: begin
                mul_a_l  = h0_q;
                mul_a_r  = w_q[A_U0];
                mul_b_l  = h1_q;
                mul_b_r  = w_q[A_U1];
                bias_sel = w_q[A_BO];
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                // Only the result handshake leaves HOLD. A start seen here
                // is not remembered.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, register file and datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            x1_q        <= '0;
            h0_q        <= '0;
            h1_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;

            case (state_q)
                S_IDLE: begin
                    // A write in the same cycle as an accepted start still
                    // lands. The first read is in HID0, so the new value is used.
                    if (bus.cfg_we) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (bus.cfg_addr == 4'(i)) begin
                                w_q[i] <= bus.cfg_data;
                            end
                        end
                    end
                    if (bus.start) begin
                        x0_q <= bus.x0;
                        x1_q <= bus.x1;
                    end
                end
                S_HID0: begin
                    h0_q <= relu_sum;
                end
                S_HID1: begin
                    h1_q <= relu_sum;
                end
                S_OUTN: begin
                    out_q       <= relu_sum[IW-1:0];
                    out_valid_q <= 1'b1;
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Operands are zero in IDLE and HOLD because the selects default to zero.
    assign bus.nrn_a     = prod_a;
    assign bus.nrn_b     = prod_b;
    assign bus.nrn_bias  = bias_sel;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mlp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mlp_sequencer
//
// Directed bench for mlp_sequencer. The neuron adder is modelled here as a
// plain combinational sum. Expected values are worked out by hand from the
// weights that each scenario loads.
// -----------------------------------------------------------------------------
module tb_mlp_sequencer;

    localparam int DW = 4;
    localparam int IW = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mlp_sequencer_if #(.DW(DW), .IW(IW)) bus ();

    // Shared neuron adder: sum = a + b + bias, mod 2^DW
    assign bus.nrn_sum = bus.nrn_a + bus.nrn_b + bus.nrn_bias;

    mlp_sequencer #(.DW(DW), .IW(IW), .N_HID(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------------------------------------------------------- drivers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [3:0] a, input logic [DW-1:0] d);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_data = d;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic load_weights(input logic [DW-1:0] w00, w01, w10, w11,
                                input logic [DW-1:0] u0, u1, b0, b1, bo);
        cfg_write(4'd0, w00);
        cfg_write(4'd1, w01);
        cfg_write(4'd2, w10);
        cfg_write(4'd3, w11);
        cfg_write(4'd4, u0);
        cfg_write(4'd5, u1);
        cfg_write(4'd6, b0);
        cfg_write(4'd7, b1);
        cfg_write(4'd8, bo);
    endtask

    // Leaves the DUT in HID0, 1 time unit after the accepting edge.
    task automatic pulse_start(input logic [IW-1:0] a, input logic [IW-1:0] b);
        bus.x0    = a;
        bus.x1    = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.x0    = ~a;   // later changes to x must not matter
        bus.x1    = ~b;
    endtask

    // Waits a bounded number of cycles for out_valid, then accepts the result.
    // If the wait expires, got is returned as X so that the caller's
    // comparison fails.
    task automatic collect(output logic [IW-1:0] got);
        for (int i = 0; i < 10 && !bus.out_valid; i++) begin
            tick();
        end
        if (bus.out_valid) begin
            got = bus.out;
        end else begin
            got = 'x;
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0h expected 0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
        checks++; if (bus.out !== 2'd0) begin errors++; $display("FAIL reset_out: got %0h expected 0", bus.out); end
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h000) begin errors++; $display("FAIL reset_nrn_ops: got %0h expected 0", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
    endtask

    // Scenario 1: h0=3, h1=1, out=3. Also checks the operands of every phase.
    task automatic test_basic();
        load_weights(4'h1, 4'h1, 4'h1, 4'hF, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF);
        pulse_start(2'd2, 2'd1);
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h210) begin errors++; $display("FAIL basic_hid0_ops: got %0h expected 210", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
        tick();
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h2F0) begin errors++; $display("FAIL basic_hid1_ops: got %0h expected 2f0", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
        tick();
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h31F) begin errors++; $display("FAIL basic_outn_ops: got %0h expected 31f", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out !== 2'd3) begin errors++; $display("FAIL basic_result: got valid=%0h out=%0h expected valid=1 out=3", bus.out_valid, bus.out); end
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h000) begin errors++; $display("FAIL basic_hold_ops: got %0h expected 0", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.out !== 2'd3) begin errors++; $display("FAIL basic_after_ready: got valid=%0h busy=%0h out=%0h expected 0 0 3", bus.out_valid, bus.busy, bus.out); end
    endtask

    // Scenario 2: bo=A makes the output sum E, which is negative, so out=0.
    task automatic test_relu_clamp();
        logic [IW-1:0] got;
        cfg_write(4'd8, 4'hA);
        pulse_start(2'd2, 2'd1);
        collect(got);
        checks++; if (got !== 2'd0) begin errors++; $display("FAIL relu_clamp: got %0h expected 0", got); end
    endtask

    // Scenario 3: x0=1 x1=2 with bo=F gives h0=3, h1=0 (F clamped), out=2.
    task automatic test_timing();
        cfg_write(4'd8, 4'hF);
        bus.x0    = 2'd1;
        bus.x1    = 2'd2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL timing_t0: got busy=%0h valid=%0h expected 1 0", bus.busy, bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL timing_t1_valid: got %0h expected 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL timing_t2_valid: got %0h expected 0", bus.out_valid); end
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out !== 2'd2) begin errors++; $display("FAIL timing_t3_result: got valid=%0h out=%0h expected 1 2", bus.out_valid, bus.out); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.out_valid !== 1'b1 || bus.out !== 2'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL timing_hold_%0d: got valid=%0h out=%0h busy=%0h expected 1 2 1", i, bus.out_valid, bus.out, bus.busy); end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL timing_release: got valid=%0h busy=%0h expected 0 0", bus.out_valid, bus.busy); end
    endtask

    // A write to bo together with an accepted start uses the new bo: out 3 -> 0.
    task automatic test_write_with_start();
        logic [IW-1:0] got;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'd8;
        bus.cfg_data = 4'hA;
        pulse_start(2'd2, 2'd1);
        bus.cfg_we   = 1'b0;
        collect(got);
        checks++; if (got !== 2'd0) begin errors++; $display("FAIL write_with_start: got %0h expected 0", got); end
        cfg_write(4'd8, 4'hF);
    endtask

    // Scenario 4: a cfg write and a start while busy are both dropped, and so
    // is a write to addr 9. Every run with x0=1 x1=2 must still give out=2.
    task automatic test_busy_ignore();
        logic [IW-1:0] got;
        pulse_start(2'd1, 2'd2);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 4'd0;
        bus.cfg_data = 4'h7;
        bus.start    = 1'b1;
        tick();
        bus.cfg_we   = 1'b0;
        bus.start    = 1'b0;
        collect(got);
        checks++; if (got !== 2'd2) begin errors++; $display("FAIL busy_run: got %0h expected 2", got); end
        tick();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL busy_no_queue: got busy=%0h expected 0", bus.busy); end
        pulse_start(2'd1, 2'd2);
        collect(got);
        checks++; if (got !== 2'd2) begin errors++; $display("FAIL busy_rerun: got %0h expected 2", got); end
        cfg_write(4'd9, 4'h7);
        pulse_start(2'd1, 2'd2);
        collect(got);
        checks++; if (got !== 2'd2) begin errors++; $display("FAIL addr9_dropped: got %0h expected 2", got); end
    endtask

    // Scenario 5: reset in HID1 aborts the run and clears the weights.
    task automatic test_reset_abort();
        logic [IW-1:0] got;
        pulse_start(2'd3, 2'd3);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out !== 2'd0) begin errors++; $display("FAIL abort_state: got busy=%0h valid=%0h out=%0h expected 0 0 0", bus.busy, bus.out_valid, bus.out); end
        pulse_start(2'd3, 2'd3);
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h000) begin errors++; $display("FAIL abort_hid0_ops: got %0h expected 0", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
        tick();
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h000) begin errors++; $display("FAIL abort_hid1_ops: got %0h expected 0", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
        tick();
        checks++; if ({bus.nrn_a, bus.nrn_b, bus.nrn_bias} !== 12'h000) begin errors++; $display("FAIL abort_outn_ops: got %0h expected 0", {bus.nrn_a, bus.nrn_b, bus.nrn_bias}); end
        collect(got);
        checks++; if (got !== 2'd0) begin errors++; $display("FAIL abort_zero_run: got %0h expected 0", got); end
    endtask

    // Scenario 6: start together with out_ready in HOLD only completes the
    // output handshake. Start in the next IDLE cycle begins a new run.
    task automatic test_hold_start();
        logic [IW-1:0] got;
        load_weights(4'h1, 4'h1, 4'h1, 4'hF, 4'h1, 4'h1, 4'h0, 4'h0, 4'hF);
        pulse_start(2'd2, 2'd1);
        tick();
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out !== 2'd3) begin errors++; $display("FAIL hold_result: got valid=%0h out=%0h expected 1 3", bus.out_valid, bus.out); end
        bus.x0        = 2'd2;
        bus.x1        = 2'd1;
        bus.start     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_start_ignored: got busy=%0h valid=%0h expected 0 0", bus.busy, bus.out_valid); end
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_restart: got busy=%0h expected 1", bus.busy); end
        collect(got);
        checks++; if (got !== 2'd3) begin errors++; $display("FAIL hold_restart_result: got %0h expected 3", got); end
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.start     = 1'b0;
        bus.x0        = '0;
        bus.x1        = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_basic();
        test_relu_clamp();
        test_timing();
        test_write_with_start();
        test_busy_ignore();
        test_reset_abort();
        test_hold_start();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
